// File: rtl/eco_seq_pkg.sv
// Shared constants for the ECO equivalence sequencer: controller state codes and
// the field layout of a mismatch log record.
package eco_seq_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_COMPARE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Log record is {a, b, y_orig, y_rev}, MSB first; field index counts from the LSB.
  localparam int unsigned LOG_FIELDS     = 4;
  localparam int unsigned LOG_FLD_Y_REV  = 0;
  localparam int unsigned LOG_FLD_Y_ORIG = 1;
  localparam int unsigned LOG_FLD_B      = 2;
  localparam int unsigned LOG_FLD_A      = 3;

  function automatic int unsigned log_lsb(input int unsigned fld, input int unsigned w);
    return fld * w;
  endfunction

endpackage

// File: rtl/eco_log_fifo.sv
// Mismatch log FIFO: push side drops (and flags) when full unless a pop frees the slot
// in the same cycle; head entry is presented combinationally with valid/ready pop.
module eco_log_fifo #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          r_overflow;

  logic w_full;
  logic w_pop;
  logic w_wr;

  assign w_full     = (r_cnt == FULL_CNT);
  assign o_valid    = (r_cnt != '0);
  assign w_pop      = o_valid && i_ready;
  // When full, the slot under wr_ptr is the head being popped, so it can be reused.
  assign w_wr       = i_push && (!w_full || w_pop);
  assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr && !w_pop) begin
        r_cnt <= r_cnt + (AW + 1)'(1);
      end else if (w_pop && !w_wr) begin
        r_cnt <= r_cnt - (AW + 1)'(1);
      end
      if (i_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_clr) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

endmodule

// File: rtl/eco_equiv_sequencer.sv
// Drives every {a, b} vector into the original and ECO-revised netlists, compares their
// outputs after a settle window, counts mismatches and logs them for readout.
module eco_equiv_sequencer
  import eco_seq_pkg::*;
#(
  parameter int unsigned W             = 4,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned LOG_DEPTH     = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_abort,
  output logic [W-1:0]        o_dut_a,
  output logic [W-1:0]        o_dut_b,
  input  logic [W-1:0]        i_y_orig,
  input  logic [W-1:0]        i_y_rev,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_equivalent,
  output logic [2*W:0]        o_mismatch_cnt,
  output logic                o_log_overflow,
  output logic                o_log_valid,
  input  logic                i_log_ready,
  output logic [4*W-1:0]      o_log_data
);

  localparam int unsigned VW   = 2 * W;
  localparam int unsigned CNTW = 2 * W + 1;
  localparam int unsigned LW   = LOG_FIELDS * W;
  localparam int unsigned SCW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SCW-1:0] SETTLE_RELOAD = SCW'(SETTLE_CYCLES - 1);

  localparam int unsigned OFF_A      = log_lsb(LOG_FLD_A, W);
  localparam int unsigned OFF_B      = log_lsb(LOG_FLD_B, W);
  localparam int unsigned OFF_Y_ORIG = log_lsb(LOG_FLD_Y_ORIG, W);
  localparam int unsigned OFF_Y_REV  = log_lsb(LOG_FLD_Y_REV, W);

  logic [1:0]      r_state;
  logic [VW-1:0]   r_vec;
  logic [SCW-1:0]  r_settle;
  logic [CNTW-1:0] r_mm_cnt;

  logic          w_start_ok;
  logic          w_clr;
  logic          w_miss;
  logic [LW-1:0] w_log_entry;

  assign w_start_ok = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_clr      = w_start_ok && !i_abort;
  // Abort suppresses the compare side effects of the cycle it lands on.
  assign w_miss     = (r_state == ST_COMPARE) && !i_abort && (i_y_orig != i_y_rev);

  always_comb begin
    w_log_entry                      = '0;
    w_log_entry[OFF_A +: W]          = r_vec[VW-1:W];
    w_log_entry[OFF_B +: W]          = r_vec[W-1:0];
    w_log_entry[OFF_Y_ORIG +: W]     = i_y_orig;
    w_log_entry[OFF_Y_REV +: W]      = i_y_rev;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_vec    <= '0;
      r_settle <= '0;
      r_mm_cnt <= '0;
    end else if (i_abort) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_mm_cnt <= '0;
            r_vec    <= '0;
            r_settle <= SETTLE_RELOAD;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= ST_COMPARE;
          end else begin
            r_settle <= r_settle - SCW'(1);
          end
        end
        ST_COMPARE: begin
          if (w_miss) begin
            r_mm_cnt <= r_mm_cnt + CNTW'(1);
          end
          if (r_vec == '1) begin
            r_state <= ST_DONE;
          end else begin
            r_vec    <= r_vec + VW'(1);
            r_settle <= SETTLE_RELOAD;
            r_state  <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  eco_log_fifo #(
    .DW    (LW),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_clr),
    .i_push      (w_miss),
    .i_push_data (w_log_entry),
    .i_ready     (i_log_ready),
    .o_valid     (o_log_valid),
    .o_data      (o_log_data),
    .o_overflow  (o_log_overflow)
  );

  assign o_dut_a        = r_vec[VW-1:W];
  assign o_dut_b        = r_vec[W-1:0];
  assign o_busy         = (r_state == ST_SETTLE) || (r_state == ST_COMPARE);
  assign o_done         = (r_state == ST_DONE);
  assign o_equivalent   = o_done && (r_mm_cnt == '0);
  assign o_mismatch_cnt = r_mm_cnt;

endmodule

// File: tb/tb_eco_equiv_sequencer.sv
// Self-checking bench: full scans against a queue-based reference of the mismatch log,
// plus abort and asynchronous-reset sequences.
module tb_eco_equiv_sequencer;

  localparam int W  = 4;
  localparam int S  = 1;
  localparam int D  = 4;
  localparam int NV = 256;
  localparam int N  = NV * (S + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        log_ready;
  logic [3:0]  dut_a;
  logic [3:0]  dut_b;
  logic [3:0]  y_orig;
  logic [3:0]  y_rev;
  logic        busy;
  logic        done;
  logic        equivalent;
  logic [8:0]  mm_cnt;
  logic        ovf;
  logic        log_valid;
  logic [15:0] log_data;

  logic [3:0]  flip_tbl [NV];

  // Stand-ins for the two netlists: revised = original with a per-vector bit flip.
  assign y_orig = dut_a + dut_b;
  assign y_rev  = y_orig ^ flip_tbl[{dut_a, dut_b}];

  always #5 clk = ~clk;

  eco_equiv_sequencer #(
    .W             (W),
    .SETTLE_CYCLES (S),
    .LOG_DEPTH     (D)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_abort        (abort),
    .o_dut_a        (dut_a),
    .o_dut_b        (dut_b),
    .i_y_orig       (y_orig),
    .i_y_rev        (y_rev),
    .o_busy         (busy),
    .o_done         (done),
    .o_equivalent   (equivalent),
    .o_mismatch_cnt (mm_cnt),
    .o_log_overflow (ovf),
    .o_log_valid    (log_valid),
    .i_log_ready    (log_ready),
    .o_log_data     (log_data)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] q [$];
  int          m_cnt;
  bit          m_ovf;

  typedef struct {
    int flip_kind;   // 0 none, 1 single at a=3,b=5, 2 all inverted, 3 random sparse
    int ready_kind;  // 0 low, 1 high, 2 random, 3 low until edge 40
    int exp_cnt;     // -1: take from reference model
    int exp_ovf;
    int exp_equiv;
  } scen_t;

  scen_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_flips(input int kind);
    for (int k = 0; k < NV; k++) begin
      case (kind)
        1:       flip_tbl[k] = (k == 8'h35) ? 4'b0001 : 4'b0000;
        2:       flip_tbl[k] = 4'hF;
        3:       flip_tbl[k] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
        default: flip_tbl[k] = 4'h0;
      endcase
    end
  endtask

  function automatic bit ready_at(input int kind, input int e);
    case (kind)
      1:       return 1'b1;
      2:       return ($urandom_range(0, 1) == 1);
      3:       return (e >= 40);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] entry_for(input int k);
    logic [7:0] kv;
    logic [3:0] a, b, yo;
    kv = 8'(k);
    a  = kv[7:4];
    b  = kv[3:0];
    yo = a + b;
    return {a, b, yo, yo ^ flip_tbl[kv]};
  endfunction

  task automatic drain();
    log_ready = 1'b1;
    while (q.size() > 0) begin
      chk("drain_valid", 32'(log_valid), 32'd1);
      chk("drain_data", 32'(log_data), 32'(q[0]));
      @(posedge clk);
      void'(q.pop_front());
      @(negedge clk);
    end
    log_ready = 1'b0;
    chk("drain_empty", 32'(log_valid), 32'd0);
  endtask

  task automatic run_scan(input scen_t s);
    bit r;
    fill_flips(s.flip_kind);
    q.delete();
    m_cnt     = 0;
    m_ovf     = 1'b0;
    log_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_cnt", 32'(mm_cnt), 32'd0);
    chk("start_ovf", 32'(ovf), 32'd0);
    chk("start_done", 32'(done), 32'd0);
    chk("start_vec", 32'({dut_a, dut_b}), 32'd0);
    for (int e = 1; e <= N; e++) begin
      r         = ready_at(s.ready_kind, e);
      log_ready = r;
      chk("run_valid", 32'(log_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("run_data", 32'(log_data), 32'(q[0]));
      chk("run_busy", 32'({busy, done}), 32'b10);
      @(posedge clk);
      if (r && q.size() != 0) void'(q.pop_front());
      if (e % (S + 1) == 0) begin
        int k;
        k = e / (S + 1) - 1;
        if (flip_tbl[k] != 4'h0) begin
          m_cnt++;
          if (q.size() < D) q.push_back(entry_for(k));
          else              m_ovf = 1'b1;
        end
      end
      @(negedge clk);
    end
    log_ready = 1'b0;
    chk("end_done", 32'({busy, done}), 32'b01);
    chk("end_cnt", 32'(mm_cnt), (s.exp_cnt >= 0) ? 32'(s.exp_cnt) : 32'(m_cnt));
    chk("end_ovf", 32'(ovf), (s.exp_ovf >= 0) ? 32'(s.exp_ovf) : 32'(m_ovf));
    chk("end_equiv", 32'(equivalent), (s.exp_equiv >= 0) ? 32'(s.exp_equiv) : 32'(m_cnt == 0));
    chk("end_vec", 32'({dut_a, dut_b}), 32'hFF);
    if (s.flip_kind == 1) chk("single_entry", 32'(log_data), 32'h3589);
    drain();
  endtask

  initial begin
    tbl[0] = '{flip_kind: 0, ready_kind: 1, exp_cnt: 0,   exp_ovf: 0,  exp_equiv: 1};
    tbl[1] = '{flip_kind: 1, ready_kind: 0, exp_cnt: 1,   exp_ovf: 0,  exp_equiv: 0};
    tbl[2] = '{flip_kind: 2, ready_kind: 0, exp_cnt: 256, exp_ovf: 1,  exp_equiv: 0};
    tbl[3] = '{flip_kind: 2, ready_kind: 1, exp_cnt: 256, exp_ovf: 0,  exp_equiv: 0};
    tbl[4] = '{flip_kind: 2, ready_kind: 3, exp_cnt: 256, exp_ovf: 1,  exp_equiv: 0};
    tbl[5] = '{flip_kind: 3, ready_kind: 2, exp_cnt: -1,  exp_ovf: -1, exp_equiv: -1};

    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    log_ready = 1'b0;
    fill_flips(0);
    @(negedge clk);
    chk("reset_outs", 32'({busy, done, equivalent, ovf, log_valid}), 32'd0);
    chk("reset_cnt", 32'(mm_cnt), 32'd0);
    chk("reset_vec", 32'({dut_a, dut_b}), 32'd0);
    chk("reset_data", 32'(log_data), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_scan(tbl[i]);

    // Abort when vector 0x40 is presented, with every vector mismatching.
    fill_flips(2);
    log_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 600 && {dut_a, dut_b} != 8'h40; i++) @(negedge clk);
    chk("abort_reach", 32'({dut_a, dut_b}), 32'h40);
    chk("abort_pre_cnt", 32'(mm_cnt), 32'd64);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 32'({busy, done}), 32'b00);
    chk("abort_cnt", 32'(mm_cnt), 32'd64);
    chk("abort_vec", 32'({dut_a, dut_b}), 32'h40);
    repeat (3) @(negedge clk);
    chk("abort_hold", 32'({busy, done, mm_cnt}), 32'd64);
    run_scan(tbl[2]);

    // Asynchronous reset mid-SETTLE with start held high.
    fill_flips(2);
    log_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    start = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_outs", 32'({busy, done, equivalent, ovf, log_valid}), 32'd0);
    chk("arst_cnt", 32'(mm_cnt), 32'd0);
    chk("arst_vec", 32'({dut_a, dut_b}), 32'd0);
    chk("arst_data", 32'(log_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_vec", 32'({dut_a, dut_b}), 32'd0);
    repeat (4) @(negedge clk);
    chk("start_ignored", 32'({dut_a, dut_b}), 32'h02);
    start = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("final_idle", 32'({busy, done}), 32'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eco_equiv_sequencer.md
Name: eco_equiv_sequencer

Overview:
- Sequential controller that drives exhaustive input vectors into two W-bit gate-level datapath instances: the original netlist and the ECO-revised netlist.
- Compares their outputs vector by vector, counts mismatches and buffers mismatch records in a small log FIFO for readout.
- Sits in the ECO test harness as the single driver of both netlist instances' a/b inputs.

Parameters:
- W, 4, datapath operand and output width (a, b, y each W bits)
- SETTLE_CYCLES, 1, cycles to hold each vector before comparing (min 1)
- LOG_DEPTH, 4, mismatch log FIFO entries (power of 2, min 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  begin run; honoured only in IDLE or DONE
- abort  in  1  terminate run, return to IDLE
- dut_a  out  W  operand a to both netlists (registered)
- dut_b  out  W  operand b to both netlists (registered)
- y_orig  in  W  original netlist output
- y_rev  in  W  revised netlist output
- busy  out  1  high in SETTLE/COMPARE
- done  out  1  high in DONE
- equivalent  out  1  valid when done; 1 iff mismatch_cnt==0
- mismatch_cnt  out  2W+1  mismatching vectors this run
- log_overflow  out  1  sticky; a mismatch record was dropped
- log_valid  out  1  log FIFO non-empty
- log_ready  in  1  consumer accepts head entry
- log_data  out  4W  {a, b, y_orig, y_rev}, MSB first

Behaviour:
- Reset (async, any state): state=IDLE. dut_a=dut_b=0, busy=done=equivalent=0, mismatch_cnt=0, log_overflow=0, FIFO empty (log_valid=0, log_data=0).
- Vector register vec is 2W bits; dut_a=vec[2W-1:W], dut_b=vec[W-1:0].
- IDLE: on start, clear mismatch_cnt, log_overflow and FIFO; vec=0; settle counter=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: count down. At 0, go to COMPARE.
- COMPARE (one cycle):
  - Sample y_orig vs y_rev. If they differ: mismatch_cnt+1; push {dut_a, dut_b, y_orig, y_rev}.
  - If vec all-ones, go to DONE. Otherwise vec+1, reload settle counter, go to SETTLE.
- Timing: each vector occupies SETTLE_CYCLES+1 cycles. done rises 2^(2W)*(SETTLE_CYCLES+1) cycles after the edge that sampled start (512 at defaults).
- DONE: done=1, equivalent=(mismatch_cnt==0). dut_a/dut_b hold the last vector. start here restarts as from IDLE (done falls the next cycle).
- start while busy is ignored.
- abort (priority over start and normal transitions):
  - Any state goes to IDLE next edge; busy=done=0.
  - mismatch_cnt, log contents and log_overflow hold for inspection.
  - dut_a/dut_b hold.
- Log FIFO:
  - Pop on log_valid && log_ready. log_data is the head entry, combinational from storage.
  - Push while full is dropped and sets log_overflow, unless a pop occurs the same cycle; then the push is accepted.
  - Push and pop together when non-full: occupancy unchanged.
  - Pointers wrap modulo LOG_DEPTH.
  - Pops are allowed in any state, including during a run.
- mismatch_cnt never wraps; max 2^(2W) fits in 2W+1 bits.

Decomposition:
- Package eco_seq_pkg:
  - state enum {IDLE, SETTLE, COMPARE, DONE}
  - log field offsets/widths as localparams derived from W
- Sub-module eco_log_fifo: parameterised by data width and depth, with push/full/overflow and valid/ready pop. Instantiated once.

Test Plan:
- Identical netlists, defaults, start pulse: done at cycle 512, mismatch_cnt=0, equivalent=1, log_valid=0 throughout, final dut_a=dut_b=4'hF.
- y_rev = y_orig^4'b0001 only when a=3, b=5: mismatch_cnt=1, equivalent=0, single log entry 16'h35?? with y_orig/y_rev differing in bit 0, log_overflow=0.
- y_rev = ~y_orig always, log_ready=0: mismatch_cnt=256, FIFO holds vectors 0x00..0x03, log_overflow=1. Draining with log_ready=1 yields exactly 4 entries in order.
- Same stimulus with log_ready tied 1: no overflow, 256 entries popped in vec order. Also cover simultaneous push/pop at full occupancy.
- abort asserted when vec=0x40: IDLE next cycle, busy=0, done=0, mismatch_cnt holds. A subsequent start clears it and rescans from vec 0.
- rst asserted mid-SETTLE with start held high: all outputs zero immediately (async). After deassert, a new run begins on the first sampled start.
